// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: sequencing controller for a 1-to-8 demux datapath.
// Takes one valid/ready word stream and places each word in a one-entry
// output register. The destination is either round-robin in bursts over the
// enabled channels (mode 0) or the per-word in_dest (mode 1). The word is
// held until the selected channel accepts it.
module demux_dispatch_ctrl #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [2:0]   in_dest,
  input  logic [7:0]   en_mask,
  output logic [W-1:0] out_data,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [2:0]   sel,
  output logic         busy,
  output logic         drop
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [3:0]   burst_cnt, burst_nxt, cnt_eff;
  logic [2:0]   last_rr, last_rr_nxt;
  logic         prev_mode, mode_chg;
  logic         full, fire, accept, keep, rr_keep;
  logic [2:0]   dest, rr_pick, sel_nxt;
  logic [W-1:0] data_nxt;
  logic         drop_nxt;

  assign full      = (state == HOLD);
  assign busy      = full;
  assign fire      = full & out_ready[sel];
  assign out_valid = full ? (8'd1 << sel) : 8'd0;

  // Round-robin needs at least one enabled channel before it can take a word.
  assign in_ready  = (~full | fire) & (mode | (en_mask != 8'd0));
  assign accept    = in_valid & in_ready;

  // A mode change looks like a fresh start to the burst counter. It applies
  // to an accept in the same cycle, because prev_mode still holds the old mode.
  assign mode_chg  = (mode != prev_mode);
  assign cnt_eff   = mode_chg ? 4'd0 : burst_cnt;

  // Stay on the current channel only while a burst is in progress and has
  // room left. A count of 0 means no burst is open, which is the case after
  // reset and after a mode change. With BURST=16 the 4-bit count wraps to 0
  // after the 16th word, and that wrap closes the burst.
  assign rr_keep   = (cnt_eff != 4'd0) && ({1'b0, cnt_eff} < 5'(BURST))
                     && en_mask[last_rr];

  assign keep      = mode ? en_mask[in_dest] : 1'b1;
  assign dest      = mode ? in_dest : (rr_keep ? last_rr : rr_pick);

  // First enabled channel after last_rr, with wrap. The scan runs from the far
  // end back toward the near end, so the nearest hit is written last. The
  // offset-8 slot is last_rr itself.
  always_comb begin
    rr_pick = last_rr;
    for (int i = 8; i >= 1; i--) begin
      if (en_mask[last_rr + 3'(i)])
        rr_pick = last_rr + 3'(i);
    end
  end

  // Next-state and register update. An accept that keeps its word takes
  // priority over the drain, so fire and accept together give no bubble.
  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    data_nxt    = out_data;
    burst_nxt   = cnt_eff;
    last_rr_nxt = last_rr;
    drop_nxt    = 1'b0;
    if (fire)
      state_nxt = EMPTY;
    if (accept) begin
      if (!mode) begin
        if (rr_keep) begin
          burst_nxt = cnt_eff + 4'd1;
        end else begin
          burst_nxt   = 4'd1;
          last_rr_nxt = rr_pick;
        end
      end
      if (keep) begin
        state_nxt = HOLD;
        sel_nxt   = dest;
        data_nxt  = in_data;
      end else begin
        drop_nxt = 1'b1;
      end
    end
  end

  // State and datapath registers. Reset discards any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_data  <= '0;
      sel       <= 3'd0;
      burst_cnt <= 4'd0;
      last_rr   <= 3'd7;
      prev_mode <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_data  <= data_nxt;
      sel       <= sel_nxt;
      burst_cnt <= burst_nxt;
      last_rr   <= last_rr_nxt;
      prev_mode <= mode;
      drop      <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Scoreboard bench for demux_dispatch_ctrl. The stimulus pushes the expected
// {channel, data} for each kept word. A negedge monitor pops one entry on
// every output handshake and compares it.
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [2:0] in_dest;
  logic [7:0] en_mask;
  logic [7:0] out_data;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [2:0] sel;
  logic       busy;
  logic       drop;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  demux_dispatch_ctrl #(.W(8), .BURST(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .in_dest(in_dest), .en_mask(en_mask),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && ((out_valid & out_ready) != 8'd0)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_fire: out_valid=%0h out_data=%0h expected none",
                 out_valid, out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_valid", 32'(out_valid), 32'(8'd1 << e.ch));
        chk("mon_data", 32'(out_data), 32'(e.d));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    q.delete();
    rst = 1'b0;
  endtask

  // Offer one word and wait, with a bound, for it to be accepted.
  task automatic send(input logic [7:0] d, input logic [2:0] dst,
                      input logic [2:0] exp_ch, input bit exp_keep);
    int n;
    n = 0;
    in_data  = d;
    in_dest  = dst;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck at 0 for word %0h, expected 1", d);
    end else if (exp_keep) begin
      q.push_back('{ch: exp_ch, d: d});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int t0;
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; mode = 1'b0;
    in_dest = 3'd0; en_mask = 8'hFF; out_ready = 8'hFF;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_drop", 32'(drop), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    // Round-robin over all channels, back to back
    t0 = cyc;
    for (int i = 0; i < 12; i++)
      send(8'hD0 + 8'(i), 3'd0, 3'(i / 4), 1'b1);
    chk("rr_throughput", 32'(cyc - t0), 32'd12);
    drain();

    // Sparse mask 0x24, then channel 5 disabled mid-stream
    do_reset();
    en_mask = 8'h24;
    send(8'h10, 3'd0, 3'd2, 1'b1);
    send(8'h11, 3'd0, 3'd2, 1'b1);
    send(8'h12, 3'd0, 3'd2, 1'b1);
    send(8'h13, 3'd0, 3'd2, 1'b1);
    send(8'h14, 3'd0, 3'd5, 1'b1);
    send(8'h15, 3'd0, 3'd5, 1'b1);
    en_mask = 8'h04;
    send(8'h16, 3'd0, 3'd2, 1'b1);
    drain();

    // Directed to channel 6 with back-pressure
    do_reset();
    mode = 1'b1; en_mask = 8'hFF; out_ready = 8'hBF;
    send(8'hA6, 3'd6, 3'd6, 1'b1);
    in_data = 8'hB6; in_dest = 3'd6; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'h40);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out_data", 32'(out_data), 32'hA6);
      @(posedge clk); #1;
    end
    out_ready = 8'hFF;
    q.push_back('{ch: 3'd6, d: 8'hB6});
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Directed to a disabled channel: dropped
    do_reset();
    mode = 1'b1; en_mask = 8'hF7;
    send(8'hC3, 3'd3, 3'd3, 1'b0);
    @(negedge clk);
    chk("drop_pulse", 32'(drop), 32'h1);
    chk("drop_out_valid", 32'(out_valid), 32'h0);
    chk("drop_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_clear", 32'(drop), 32'h0);
    @(posedge clk); #1;

    // Round-robin with an empty mask
    do_reset();
    mode = 1'b0; en_mask = 8'h00;
    in_data = 8'hE7; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("nomask_in_ready", 32'(in_ready), 32'h0);
      chk("nomask_busy", 32'(busy), 32'h0);
      @(posedge clk); #1;
    end
    en_mask = 8'h80;
    send(8'hE7, 3'd0, 3'd7, 1'b1);
    drain();

    // Reset while a word is held
    do_reset();
    mode = 1'b1; en_mask = 8'hFF; out_ready = 8'h00;
    send(8'h55, 3'd5, 3'd5, 1'b1);
    @(negedge clk);
    chk("hold_busy", 32'(busy), 32'h1);
    chk("hold_sel", 32'(sel), 32'h5);
    @(posedge clk); #1;
    mode = 1'b0;
    do_reset();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_sel", 32'(sel), 32'h0);
    @(posedge clk); #1;
    out_ready = 8'hFF;
    send(8'h66, 3'd0, 3'd0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
